display_selector: RTL and testbench
===================================

# display_selector

Registered display-source selector feeding the calculator's 7-segment driver. Picks one of `N_SRC` operand/result buses according to the control FSM's selector and holds it stable for the driver. It adds the behaviour the calculator needs on top of a plain mux:
- blanking;
- blinking of the value being entered;
- a sticky error indication;
- a hold/freeze input;
- a one-cycle update strobe when the displayed value changes.

## Interface
- `WIDTH`, 16, bit width of every source bus and of `SALIDA`.
- `N_SRC`, 3, number of source buses (calculator: 1 = operand A, 2 = operand B, 3 = result).
- `BLINK_DIV`, 25_000_000, clock cycles per blink half-period; must be ≥ 2.
- `SEL_W`, `$clog2(N_SRC+1)`, selector width (derived; not overridden).
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `SEL` in `SEL_W`: 0 = blank; k in 1..`N_SRC` = source k−1; values > `N_SRC` are treated as 0.
- `SRC` in `N_SRC`×`WIDTH`: packed array of source buses.
- `BLINK_EN` in 1: blink the displayed value while set (FSM drives it during operand entry).
- `HOLD` in 1: freeze `SALIDA`.
- `ERR` in 1: error pulse from ALU (overflow, divide by zero).
- `SALIDA` out `WIDTH`: value to display.
- `BLANK` out 1: driver must turn all digits off.
- `ERR_FLAG` out 1: sticky error; driver shows the error pattern.
- `UPDATE` out 1: one-cycle strobe after `SALIDA` changes.

## Operation
- All outputs are registered. `RESET` dominates every other input.
- **Reset values:**
  - `SALIDA`=0, `BLANK`=1, `ERR_FLAG`=0, `UPDATE`=0.
  - Blink counter=0, blink phase=visible.
- **Selection:**
  - Each cycle with `HOLD`=0 and `ERR_FLAG`=0:
    - `SEL` in 1..`N_SRC`: `SALIDA` ← `SRC[SEL-1]`.
    - `SEL`=0 or out of range: `SALIDA` ← 0.
  - With `HOLD`=1, or `ERR_FLAG`=1 (including the cycle it is set), `SALIDA` keeps its value.
- **BLANK** next value is 1 if any of the following holds, otherwise 0:
  - effective `SEL`=0 and `ERR_FLAG` next=0;
  - `BLINK_EN`=1, effective `SEL`≠0, `ERR_FLAG` next=0, and phase=hidden.

  `ERR_FLAG`=1 always forces `BLANK`=0.
- **Blink timer:**
  - The counter runs 0..`BLINK_DIV`−1 and toggles the phase on wrap. The first phase after a restart is visible.
  - The timer restarts (counter=0, phase=visible) when `SEL` differs from its previous-cycle value, or when `BLINK_EN`=0.
  - It keeps running during `HOLD`.
- **Error:**
  - `ERR`=1 sets `ERR_FLAG`.
  - `ERR_FLAG` clears only on `RESET`, or on a cycle where `SEL`=0 and `ERR`=0.
  - If `ERR`=1 and `SEL`=0 in the same cycle, the set wins.
- **Update strobe:**
  - `UPDATE`=1 for exactly one cycle, the cycle after the `SALIDA` register loads a value different from its previous value.
  - There is no strobe on reset, and no strobe when a reload produces the same value.
- **Width:**
  - No arithmetic on data paths. Sources pass through bit-exact.
  - Out-of-range `SEL` decodes as 0, never as X.

## Timing
- Latency from `SEL`/`SRC` to `SALIDA` is 1 cycle. `BLANK` and `ERR_FLAG` also take 1 cycle.
- `UPDATE` is asserted 1 cycle after `SALIDA` changes, i.e. 2 cycles after the causing input.
- `SRC` changes with `SEL` constant are tracked every cycle, so live operand entry shows immediately.
- **Blink timing:** with `BLINK_EN` held and `SEL` constant, `BLANK` follows this pattern:
  - 0 for `BLINK_DIV` cycles;
  - then 1 for `BLINK_DIV` cycles;
  - repeating.
- **Reset mid-operation:** the next edge yields the reset values regardless of `HOLD`, `ERR` or the blink phase.
- **`HOLD` released:** `SALIDA` reloads on the next edge and may produce `UPDATE` one cycle later.

## Structure
- **Shared package `calc_pkg`** holds:
  - `localparam SEL_BLANK = 0`, plus named selector constants `SEL_OP_A`=1, `SEL_OP_B`=2, `SEL_RES`=3 used by the control FSM;
  - the default `WIDTH`.
- **Sub-module `blink_timer`** (parameter `BLINK_DIV`):
  - inputs `CLK`, `RESET`, `RESTART`, `EN`;
  - output `PHASE_HIDDEN`.
- The selection, error and update logic stays in `display_selector`.

## Test plan
All scenarios use `WIDTH`=16, `N_SRC`=3, `BLINK_DIV`=4.
1. Reset, then `SEL`=2 with `SRC[1]`=16'h00A5 → `SALIDA`=16'h00A5 after 1 cycle; `UPDATE` pulses once 1 cycle later; `BLANK`=0.
2. `SEL`=1, `BLINK_EN`=1, `SRC` constant → `BLANK` sequence 0,0,0,0,1,1,1,1,0…. Changing `SEL` to 2 mid-hidden restarts the sequence with 4 visible cycles.
3. `SEL`=3 showing 16'h1234, `ERR` pulse while `SRC[2]` becomes 16'hFFFF → `SALIDA` stays 16'h1234, `ERR_FLAG`=1, `BLANK`=0. `SEL`=0 with `ERR`=0 clears the flag and sets `SALIDA`=0, `BLANK`=1.
4. `HOLD`=1 while `SRC[0]` changes 16'h0001→16'h0002 → `SALIDA` stays 16'h0001 with no `UPDATE`. On `HOLD` release, `SALIDA`=16'h0002 and `UPDATE` pulses.
5. Same cycle `ERR`=1 and `SEL`=0 → `ERR_FLAG`=1. `SEL`=3'b111 (out of range, `SEL_W`=2 → use value 3 for `N_SRC`=2 build) decodes as blank: `SALIDA`=0, `BLANK`=1.
6. `RESET` asserted during the blink hidden phase with `ERR_FLAG`=1 → next edge: `SALIDA`=0, `BLANK`=1, `ERR_FLAG`=0, `UPDATE`=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator constants: display selector codes and the default data width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Selector codes driven by the control FSM onto display_selector.SEL.
    localparam int SEL_BLANK = 0;
    localparam int SEL_OP_A  = 1;
    localparam int SEL_OP_B  = 2;
    localparam int SEL_RES   = 3;

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator: BLINK_DIV visible cycles, then BLINK_DIV hidden cycles, repeating.
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RESTART,
    input  logic EN,
    output logic PHASE_HIDDEN
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic [CNT_W-1:0] w_cnt_cur;
    logic             w_phase_cur;
    logic             w_wrap;

    // A restart acts on the current cycle, so that cycle is already the first visible one.
    always_comb begin
        w_cnt_cur   = RESTART ? '0 : r_cnt;
        w_phase_cur = RESTART ? 1'b0 : r_phase;
        w_wrap      = (w_cnt_cur == CNT_LAST);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET || !EN) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~w_phase_cur;
        end else begin
            r_cnt   <= w_cnt_cur + CNT_W'(1);
            r_phase <= w_phase_cur;
        end
    end

    assign PHASE_HIDDEN = EN & w_phase_cur;

endmodule

// File: rtl/display_selector.sv
// Registered display-source mux for the 7-segment driver with blanking, blink,
// sticky error, hold and a change strobe.
module display_selector
    import calc_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int N_SRC     = 3,
    parameter  int BLINK_DIV = 25_000_000,
    localparam int SEL_W     = $clog2(N_SRC + 1)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [SEL_W-1:0]            SEL,
    input  logic [N_SRC-1:0][WIDTH-1:0] SRC,
    input  logic                        BLINK_EN,
    input  logic                        HOLD,
    input  logic                        ERR,
    output logic [WIDTH-1:0]            SALIDA,
    output logic                        BLANK,
    output logic                        ERR_FLAG,
    output logic                        UPDATE
);

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_SRC);

    logic [WIDTH-1:0] r_salida;
    logic             r_blank;
    logic             r_err_flag;
    logic             r_changed;
    logic             r_update;
    logic [SEL_W-1:0] r_sel_prev;

    logic [SEL_W-1:0] w_sel_eff;
    logic [WIDTH-1:0] w_src_pick;
    logic             w_err_next;
    logic [WIDTH-1:0] w_salida_next;
    logic             w_blank_next;
    logic             w_restart;
    logic             w_phase_hidden;

    assign w_restart = (SEL != r_sel_prev);

    blink_timer #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink_timer (
        .CLK          (CLK),
        .RESET        (RESET),
        .RESTART      (w_restart),
        .EN           (BLINK_EN),
        .PHASE_HIDDEN (w_phase_hidden)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_sel_eff  = (SEL <= SEL_MAX) ? SEL : SEL_W'(SEL_BLANK);
        w_src_pick = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (w_sel_eff == SEL_W'(k + 1)) w_src_pick = SRC[k];
        end

        // An error pulse wins over a simultaneous blank-select clear.
        w_err_next    = ERR | (r_err_flag & (w_sel_eff != SEL_W'(SEL_BLANK)));
        w_salida_next = (HOLD || w_err_next) ? r_salida : w_src_pick;
        w_blank_next  = !w_err_next &&
                        ((w_sel_eff == SEL_W'(SEL_BLANK)) || (BLINK_EN && w_phase_hidden));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_salida   <= '0;
            r_blank    <= 1'b1;
            r_err_flag <= 1'b0;
            r_changed  <= 1'b0;
            r_update   <= 1'b0;
            r_sel_prev <= '0;
        end else begin
            r_salida   <= w_salida_next;
            r_blank    <= w_blank_next;
            r_err_flag <= w_err_next;
            r_changed  <= (w_salida_next != r_salida);
            r_update   <= r_changed;
            r_sel_prev <= SEL;
        end
    end

    assign SALIDA   = r_salida;
    assign BLANK    = r_blank;
    assign ERR_FLAG = r_err_flag;
    assign UPDATE   = r_update;

endmodule

// File: tb/tb_display_selector.sv
// Directed bench for display_selector: per-cycle expectations go through a scoreboard queue.
module tb_display_selector;

    typedef struct packed {
        logic [15:0] salida;
        logic        blank;
        logic        err;
        logic        upd;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       sel;
    logic [2:0][15:0] src;
    logic             blink, hold, err;
    logic [15:0]      salida;
    logic             blank, err_flag, update;

    logic [1:0]       sel2;
    logic [1:0][15:0] src2;
    logic             err2;
    logic [15:0]      salida2;
    logic             blank2, err_flag2, update2;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "init";

    always #5 clk = ~clk;

    display_selector #(.WIDTH(16), .N_SRC(3), .BLINK_DIV(4)) dut (
        .CLK(clk), .RESET(rst), .SEL(sel), .SRC(src), .BLINK_EN(blink), .HOLD(hold),
        .ERR(err), .SALIDA(salida), .BLANK(blank), .ERR_FLAG(err_flag), .UPDATE(update)
    );

    display_selector #(.WIDTH(16), .N_SRC(2), .BLINK_DIV(4)) dut2 (
        .CLK(clk), .RESET(rst), .SEL(sel2), .SRC(src2), .BLINK_EN(1'b0), .HOLD(1'b0),
        .ERR(err2), .SALIDA(salida2), .BLANK(blank2), .ERR_FLAG(err_flag2), .UPDATE(update2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s [%s]: got %h, want %h", tag, phase, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, then compare once the DUT has produced it.
    task automatic cyc(input logic [15:0] s, input logic b, input logic e, input logic u);
        exp_t x;
        x = '{salida: s, blank: b, err: e, upd: u};
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("salida",   32'(salida),   32'(x.salida));
        check("blank",    32'(blank),    32'(x.blank));
        check("err_flag", 32'(err_flag), 32'(x.err));
        check("update",   32'(update),   32'(x.upd));
    endtask

    initial begin
        rst = 1'b1; sel = 2'd0; src = '0; blink = 1'b0; hold = 1'b0; err = 1'b0;
        sel2 = 2'd0; src2 = '0; err2 = 1'b0;

        phase = "reset";
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);

        phase = "select";
        rst = 1'b0; sel = 2'd2; src[1] = 16'h00A5;
        cyc(16'h00A5, 1'b0, 1'b0, 1'b0);
        cyc(16'h00A5, 1'b0, 1'b0, 1'b1);
        cyc(16'h00A5, 1'b0, 1'b0, 1'b0);

        phase = "blink";
        sel = 2'd1; blink = 1'b1; src[0] = 16'h0011;
        for (int i = 0; i < 14; i++)
            cyc(16'h0011, ((i / 4) % 2) == 1, 1'b0, i == 1);
        phase = "blink_restart";
        sel = 2'd2;
        for (int j = 0; j < 5; j++)
            cyc(16'h00A5, j == 4, 1'b0, j == 1);
        blink = 1'b0;
        cyc(16'h00A5, 1'b0, 1'b0, 1'b0);

        phase = "error";
        sel = 2'd3; src[2] = 16'h1234;
        cyc(16'h1234, 1'b0, 1'b0, 1'b0);
        cyc(16'h1234, 1'b0, 1'b0, 1'b1);
        err = 1'b1; src[2] = 16'hFFFF;
        cyc(16'h1234, 1'b0, 1'b1, 1'b0);
        err = 1'b0;
        cyc(16'h1234, 1'b0, 1'b1, 1'b0);
        sel = 2'd0;
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0000, 1'b1, 1'b0, 1'b1);
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);

        phase = "hold";
        sel = 2'd1; src[0] = 16'h0001;
        cyc(16'h0001, 1'b0, 1'b0, 1'b0);
        cyc(16'h0001, 1'b0, 1'b0, 1'b1);
        hold = 1'b1; src[0] = 16'h0002;
        cyc(16'h0001, 1'b0, 1'b0, 1'b0);
        cyc(16'h0001, 1'b0, 1'b0, 1'b0);
        hold = 1'b0;
        cyc(16'h0002, 1'b0, 1'b0, 1'b0);
        cyc(16'h0002, 1'b0, 1'b0, 1'b1);
        cyc(16'h0002, 1'b0, 1'b0, 1'b0);

        phase = "err_vs_clear";
        sel = 2'd0; err = 1'b1;
        cyc(16'h0002, 1'b0, 1'b1, 1'b0);
        err = 1'b0;
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0000, 1'b1, 1'b0, 1'b1);

        phase = "reset_mid_op";
        sel = 2'd1; blink = 1'b1;
        cyc(16'h0002, 1'b0, 1'b0, 1'b0);
        cyc(16'h0002, 1'b0, 1'b0, 1'b1);
        cyc(16'h0002, 1'b0, 1'b0, 1'b0);
        cyc(16'h0002, 1'b0, 1'b0, 1'b0);
        err = 1'b1;
        cyc(16'h0002, 1'b0, 1'b1, 1'b0);
        rst = 1'b1; hold = 1'b1;
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0; hold = 1'b0; err = 1'b0; blink = 1'b0; sel = 2'd0;
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);

        phase = "out_of_range";
        sel2 = 2'd1; src2[0] = 16'hBEEF;
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        check("n2_salida", 32'(salida2), 32'h0000_BEEF);
        check("n2_blank",  32'(blank2),  32'd0);
        sel2 = 2'd0; err2 = 1'b1;
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        check("n2_err_set",   32'(err_flag2), 32'd1);
        check("n2_salida_hd", 32'(salida2),   32'h0000_BEEF);
        check("n2_blank_err", 32'(blank2),    32'd0);
        check("n2_update",    32'(update2),   32'd1);
        sel2 = 2'd3; err2 = 1'b0;
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        check("n2_oor_salida", 32'(salida2),   32'd0);
        check("n2_oor_blank",  32'(blank2),    32'd1);
        check("n2_oor_err",    32'(err_flag2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
